// File: rtl/mips_instr_encoder_pkg.sv
// Shared MIPS encodings (opcodes, functs, mnemonic codes) and loader FSM states.
// The control decoder imports the same constants so both ends agree on the bit layout.
package mips_instr_encoder_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [3:0] {
    MN_ADD = 4'd0,
    MN_SUB = 4'd1,
    MN_AND = 4'd2,
    MN_OR  = 4'd3,
    MN_SLL = 4'd4,
    MN_SRL = 4'd5,
    MN_SLT = 4'd6,
    MN_LW  = 4'd7,
    MN_SW  = 4'd8,
    MN_BEQ = 4'd9
  } mnemT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_WR   = 2'd2
  } stateT;

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt,
                                        input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Symbolic-instruction handshake between the program source and the encoder.
interface mips_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_mnem;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;

  modport master (
    output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm,
    output in_ready
  );
endinterface

// File: rtl/mips_instr_encoder_encode.sv
// Purely combinational mapping of symbolic fields to a 32-bit MIPS word.
module mips_instr_encode
  import mips_instr_encoder_pkg::*;
(
  input  logic [3:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Shifts take no rs operand and the other R-types no shamt, so those fields are zeroed.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (mnem)
      MN_ADD:  word = rType(rs, rt, rd, 5'd0, FUNCT_ADD);
      MN_SUB:  word = rType(rs, rt, rd, 5'd0, FUNCT_SUB);
      MN_AND:  word = rType(rs, rt, rd, 5'd0, FUNCT_AND);
      MN_OR:   word = rType(rs, rt, rd, 5'd0, FUNCT_OR);
      MN_SLL:  word = rType(5'd0, rt, rd, shamt, FUNCT_SLL);
      MN_SRL:  word = rType(5'd0, rt, rd, shamt, FUNCT_SRL);
      MN_SLT:  word = rType(rs, rt, rd, 5'd0, FUNCT_SLT);
      MN_LW:   word = iType(OP_LW, rs, rt, imm);
      MN_SW:   word = iType(OP_SW, rs, rt, imm);
      MN_BEQ:  word = iType(OP_BEQ, rs, rt, imm);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: accepts symbolic instructions, encodes them and writes them to
// consecutive instruction-memory words (IDLE -> ENC -> WR, one instruction per 3 cycles).
module mips_instr_encoder
  import mips_instr_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter bit                WRAP      = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  mips_instr_encoder_if.slave inBus,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [ADDR_W:0]     words_wr,
  output logic                full,
  output logic                err_illegal
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  stateT       state;
  logic [3:0]  mnemQ;
  logic [4:0]  rsQ, rtQ, rdQ, shamtQ;
  logic [15:0] immQ;
  logic [31:0] encWord;
  logic        encIllegal;
  logic        accept;

  mips_instr_encode encoder (
    .mnem    (mnemQ),
    .rs      (rsQ),
    .rt      (rtQ),
    .rd      (rdQ),
    .shamt   (shamtQ),
    .imm     (immQ),
    .word    (encWord),
    .illegal (encIllegal)
  );

  // rst_n in the term keeps in_ready low while reset is held.
  assign inBus.in_ready = rst_n && (state == ST_IDLE) && !full && !clear;
  assign accept         = inBus.in_valid && inBus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mnemQ       <= '0;
      rsQ         <= '0;
      rtQ         <= '0;
      rdQ         <= '0;
      shamtQ      <= '0;
      immQ        <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= BASE_ADDR;
      mem_wdata   <= '0;
      words_wr    <= '0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
    end else if (clear) begin
      // mem_wdata is deliberately kept: it always shows the last encoded word.
      state       <= ST_IDLE;
      mem_we      <= 1'b0;
      mem_addr    <= BASE_ADDR;
      words_wr    <= '0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mnemQ  <= inBus.in_mnem;
            rsQ    <= inBus.in_rs;
            rtQ    <= inBus.in_rt;
            rdQ    <= inBus.in_rd;
            shamtQ <= inBus.in_shamt;
            immQ   <= inBus.in_imm;
            state  <= ST_ENC;
          end
        end
        ST_ENC: begin
          if (encIllegal) begin
            err_illegal <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            mem_wdata <= encWord;
            mem_we    <= 1'b1;
            state     <= ST_WR;
          end
        end
        ST_WR: begin
          mem_we <= 1'b0;
          state  <= ST_IDLE;
          if (words_wr != MAX_WORDS) begin
            words_wr <= words_wr + 1'b1;
          end
          if (mem_addr == LAST_ADDR) begin
            if (WRAP) begin
              mem_addr <= BASE_ADDR;
            end else begin
              full <= 1'b1;
            end
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: a default instance driven through a write scoreboard,
// plus small-memory instances for the full (no-wrap) and wrap/saturation boundaries.
module tb_mips_instr_encoder;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [8:0]  words;
  } sbEntryT;

  logic clk;
  logic rst_n;
  logic clearA, clearB, clearC;

  mips_instr_encoder_if ifA ();
  mips_instr_encoder_if ifB ();
  mips_instr_encoder_if ifC ();

  logic        weA, weB, weC;
  logic [7:0]  addrA;
  logic [1:0]  addrB, addrC;
  logic [31:0] wdataA, wdataB, wdataC;
  logic [8:0]  wordsA;
  logic [2:0]  wordsB, wordsC;
  logic        fullA, fullB, fullC;
  logic        errA, errB, errC;

  int checks = 0;
  int passes = 0;

  sbEntryT     sbA[$];
  sbEntryT     monEntry;
  logic [7:0]  expAddrA  = '0;
  logic [8:0]  expWordsA = '0;
  time         lastWeTime = 0;
  time         lastGap    = 0;

  mips_instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'd0), .WRAP(1'b0)) dutA (
    .clk(clk), .rst_n(rst_n), .clear(clearA), .inBus(ifA),
    .mem_we(weA), .mem_addr(addrA), .mem_wdata(wdataA),
    .words_wr(wordsA), .full(fullA), .err_illegal(errA)
  );

  mips_instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0), .WRAP(1'b0)) dutB (
    .clk(clk), .rst_n(rst_n), .clear(clearB), .inBus(ifB),
    .mem_we(weB), .mem_addr(addrB), .mem_wdata(wdataB),
    .words_wr(wordsB), .full(fullB), .err_illegal(errB)
  );

  mips_instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd1), .WRAP(1'b1)) dutC (
    .clk(clk), .rst_n(rst_n), .clear(clearC), .inBus(ifC),
    .mem_we(weC), .mem_addr(addrC), .mem_wdata(wdataC),
    .words_wr(wordsC), .full(fullC), .err_illegal(errC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoding built from the field positions and literal opcode/funct values.
  function automatic logic [31:0] refEnc(input logic [3:0] mn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [15:0] imm);
    logic [31:0] rsV, rtV, rdV, shV;
    rsV = 32'(rs) << 21;
    rtV = 32'(rt) << 16;
    rdV = 32'(rd) << 11;
    shV = 32'(sh) << 6;
    case (mn)
      4'd0:    return rsV | rtV | rdV | 32'h20;
      4'd1:    return rsV | rtV | rdV | 32'h22;
      4'd2:    return rsV | rtV | rdV | 32'h24;
      4'd3:    return rsV | rtV | rdV | 32'h25;
      4'd4:    return rtV | rdV | shV;
      4'd5:    return rtV | rdV | shV | 32'h02;
      4'd6:    return rsV | rtV | rdV | 32'h2A;
      4'd7:    return 32'h8C000000 | rsV | rtV | 32'(imm);
      4'd8:    return 32'hAC000000 | rsV | rtV | 32'(imm);
      4'd9:    return 32'h10000000 | rsV | rtV | 32'(imm);
      default: return 32'h0;
    endcase
  endfunction

  // Scoreboard consumer for instance A: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (weA === 1'b1) begin
      checks++;
      if (sbA.size() == 0) begin
        $display("FAIL unexpected_write addr=%0h data=%h required=no write", addrA, wdataA);
      end else begin
        monEntry = sbA.pop_front();
        if (addrA !== monEntry.addr || wdataA !== monEntry.data || wordsA !== monEntry.words)
          $display("FAIL write addr=%0h data=%h words=%0d required addr=%0h data=%h words=%0d",
                   addrA, wdataA, wordsA, monEntry.addr, monEntry.data, monEntry.words);
        else begin
          passes++;
          $display("write addr=%0h data=%h words=%0d", addrA, wdataA, wordsA);
        end
      end
      if (lastWeTime != 0) lastGap = $time - lastWeTime;
      lastWeTime = $time;
    end
  end

  task automatic sendA(input logic [3:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input bit track);
    int n;
    sbEntryT e;
    n = 0;
    @(negedge clk);
    while (ifA.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ifA.in_ready !== 1'b1) begin
      checks++;
      $display("FAIL sendA_ready actual=%b required=1", ifA.in_ready);
      return;
    end
    ifA.in_valid = 1'b1;
    ifA.in_mnem  = mn;
    ifA.in_rs    = rs;
    ifA.in_rt    = rt;
    ifA.in_rd    = rd;
    ifA.in_shamt = sh;
    ifA.in_imm   = imm;
    if (track && mn <= 4'd9) begin
      e.addr  = expAddrA;
      e.data  = refEnc(mn, rs, rt, rd, sh, imm);
      e.words = expWordsA;
      sbA.push_back(e);
      expAddrA  = expAddrA + 8'd1;
      expWordsA = expWordsA + 9'd1;
    end
    @(posedge clk);
    #1 ifA.in_valid = 1'b0;
  endtask

  task automatic driveB(input logic [3:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    while (ifB.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ifB.in_ready !== 1'b1) begin
      checks++;
      $display("FAIL driveB_ready actual=%b required=1", ifB.in_ready);
      return;
    end
    ifB.in_valid = 1'b1;
    ifB.in_mnem  = mn;
    ifB.in_rs    = rs;
    ifB.in_rt    = rt;
    ifB.in_rd    = rd;
    ifB.in_shamt = 5'd0;
    ifB.in_imm   = 16'd0;
    @(posedge clk);
    #1 ifB.in_valid = 1'b0;
  endtask

  task automatic driveC(input logic [3:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    while (ifC.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ifC.in_ready !== 1'b1) begin
      checks++;
      $display("FAIL driveC_ready actual=%b required=1", ifC.in_ready);
      return;
    end
    ifC.in_valid = 1'b1;
    ifC.in_mnem  = mn;
    ifC.in_rs    = rs;
    ifC.in_rt    = rt;
    ifC.in_rd    = rd;
    ifC.in_shamt = 5'd0;
    ifC.in_imm   = 16'd0;
    @(posedge clk);
    #1 ifC.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (weA !== 1'b0 || addrA !== 8'd0 || wdataA !== 32'd0 || wordsA !== 9'd0 ||
        fullA !== 1'b0 || errA !== 1'b0 || ifA.in_ready !== 1'b0)
      $display("FAIL reset_outputs we=%b addr=%0h wdata=%h words=%0d full=%b err=%b ready=%b required all 0",
               weA, addrA, wdataA, wordsA, fullA, errA, ifA.in_ready);
    else passes++;
    checks++;
    if (addrC !== 2'd1) $display("FAIL reset_base_addr actual=%0d required=1", addrC);
    else passes++;
    rst_n = 1'b1;
    #1;
    checks++;
    if (ifA.in_ready !== 1'b1) $display("FAIL ready_after_reset actual=%b required=1", ifA.in_ready);
    else passes++;
    $display("reset checked");
  endtask

  task automatic test_add();
    sendA(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (weA !== 1'b0) $display("FAIL add_enc_we actual=%b required=0", weA);
    else passes++;
    @(negedge clk);
    checks++;
    if (weA !== 1'b1 || addrA !== 8'd0 || wdataA !== 32'h00221820)
      $display("FAIL add_write we=%b addr=%0h data=%h required we=1 addr=0 data=00221820",
               weA, addrA, wdataA);
    else passes++;
    @(negedge clk);
    checks++;
    if (weA !== 1'b0 || wordsA !== 9'd1)
      $display("FAIL add_after we=%b words=%0d required we=0 words=1", weA, wordsA);
    else passes++;
  endtask

  task automatic test_itype();
    sendA(4'd7, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (wdataA !== 32'h8FA80004) $display("FAIL lw_word actual=%h required=8FA80004", wdataA);
    else passes++;
    sendA(4'd9, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (wdataA !== 32'h1022FFFF || wordsA !== 9'd3)
      $display("FAIL beq_word data=%h words=%0d required data=1022FFFF words=3", wdataA, wordsA);
    else passes++;
  endtask

  task automatic test_rtype_mix();
    for (int m = 0; m < 10; m++) begin
      sendA(4'(m), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            16'($urandom_range(0, 65535)), 1'b1);
    end
    repeat (3) @(negedge clk);
    sendA(4'd4, 5'd5, 5'd1, 5'd2, 5'd4, 16'hABCD, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (wdataA !== 32'h00011100) $display("FAIL sll_rs_ignored actual=%h required=00011100", wdataA);
    else passes++;
    sendA(4'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h1234, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (wdataA !== 32'h00221820) $display("FAIL add_shamt_masked actual=%h required=00221820", wdataA);
    else passes++;
  endtask

  task automatic test_illegal();
    logic [7:0]  addrBefore;
    logic [31:0] dataBefore;
    addrBefore = addrA;
    dataBefore = wdataA;
    sendA(4'd12, 5'd3, 5'd4, 5'd5, 5'd6, 16'h5555, 1'b1);
    @(negedge clk);
    checks++;
    if (errA !== 1'b0) $display("FAIL illegal_err_early actual=%b required=0", errA);
    else passes++;
    @(negedge clk);
    checks++;
    if (errA !== 1'b1 || weA !== 1'b0)
      $display("FAIL illegal_pulse err=%b we=%b required err=1 we=0", errA, weA);
    else passes++;
    @(negedge clk);
    checks++;
    if (errA !== 1'b0 || addrA !== addrBefore || wdataA !== dataBefore)
      $display("FAIL illegal_after err=%b addr=%0h data=%h required err=0 addr=%0h data=%h",
               errA, addrA, wdataA, addrBefore, dataBefore);
    else passes++;
    sendA(4'd1, 5'd9, 5'd10, 5'd11, 5'd0, 16'd0, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      sendA(4'($urandom_range(0, 9)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            16'($urandom_range(0, 65535)), 1'b1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (lastGap !== 30) $display("FAIL throughput_gap actual=%0t required=30", lastGap);
    else passes++;
  endtask

  task automatic test_clear();
    int weSeen;
    // clear asserted alongside a valid instruction: nothing may be accepted.
    @(negedge clk);
    ifA.in_valid = 1'b1;
    ifA.in_mnem  = 4'd0;
    clearA = 1'b1;
    #1;
    checks++;
    if (ifA.in_ready !== 1'b0) $display("FAIL clear_blocks_ready actual=%b required=0", ifA.in_ready);
    else passes++;
    @(negedge clk);
    clearA = 1'b0;
    ifA.in_valid = 1'b0;
    expAddrA  = '0;
    expWordsA = '0;
    weSeen = 0;
    repeat (4) begin
      @(negedge clk);
      if (weA === 1'b1) weSeen++;
    end
    checks++;
    if (weSeen != 0 || addrA !== 8'd0 || wordsA !== 9'd0)
      $display("FAIL clear_same_cycle writes=%0d addr=%0h words=%0d required 0 0 0", weSeen, addrA, wordsA);
    else passes++;
    sendA(4'd0, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 1'b1);
    repeat (3) @(negedge clk);
    // clear while the instruction sits in ENC aborts it.
    sendA(4'd1, 5'd7, 5'd8, 5'd9, 5'd0, 16'd0, 1'b0);
    @(negedge clk);
    clearA = 1'b1;
    @(negedge clk);
    clearA = 1'b0;
    expAddrA  = '0;
    expWordsA = '0;
    weSeen = 0;
    repeat (4) begin
      @(negedge clk);
      if (weA === 1'b1) weSeen++;
    end
    checks++;
    if (weSeen != 0 || addrA !== 8'd0 || wordsA !== 9'd0)
      $display("FAIL clear_in_enc writes=%0d addr=%0h words=%0d required 0 0 0", weSeen, addrA, wordsA);
    else passes++;
    sendA(4'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int n;
    sendA(4'd1, 5'd2, 5'd3, 5'd4, 5'd0, 16'd0, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (sbA.size() != 0 && n < 10);
    checks++;
    if (weA !== 1'b1) $display("FAIL mid_write_setup we=%b required=1", weA);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (weA !== 1'b0 || addrA !== 8'd0 || wdataA !== 32'd0 || wordsA !== 9'd0 ||
        fullA !== 1'b0 || errA !== 1'b0 || ifA.in_ready !== 1'b0)
      $display("FAIL reset_mid_write we=%b addr=%0h wdata=%h words=%0d full=%b err=%b ready=%b required all 0",
               weA, addrA, wdataA, wordsA, fullA, errA, ifA.in_ready);
    else passes++;
    expAddrA  = '0;
    expWordsA = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_nowrap();
    logic [31:0] w;
    int weSeen;
    for (int i = 0; i < 4; i++) begin
      driveB(4'd0, 5'(i + 1), 5'd2, 5'(i));
      w = refEnc(4'd0, 5'(i + 1), 5'd2, 5'(i), 5'd0, 16'd0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (weB !== 1'b1 || addrB !== 2'(i) || wdataB !== w)
        $display("FAIL full_write%0d we=%b addr=%0d data=%h required we=1 addr=%0d data=%h",
                 i, weB, addrB, wdataB, i, w);
      else begin
        passes++;
        $display("small write addr=%0d data=%h", addrB, wdataB);
      end
      @(negedge clk);
    end
    checks++;
    if (fullB !== 1'b1 || ifB.in_ready !== 1'b0 || wordsB !== 3'd4 || addrB !== 2'd3)
      $display("FAIL full_flag full=%b ready=%b words=%0d addr=%0d required 1 0 4 3",
               fullB, ifB.in_ready, wordsB, addrB);
    else passes++;
    ifB.in_valid = 1'b1;
    ifB.in_mnem  = 4'd0;
    weSeen = 0;
    repeat (10) begin
      @(negedge clk);
      if (weB === 1'b1) weSeen++;
    end
    checks++;
    if (weSeen != 0 || addrB !== 2'd3) $display("FAIL full_blocks writes=%0d addr=%0d required 0 3", weSeen, addrB);
    else passes++;
    clearB = 1'b1;
    @(negedge clk);
    clearB = 1'b0;
    ifB.in_valid = 1'b0;
    #1;
    checks++;
    if (addrB !== 2'd0 || fullB !== 1'b0 || wordsB !== 3'd0 || ifB.in_ready !== 1'b1)
      $display("FAIL full_clear addr=%0d full=%b words=%0d ready=%b required 0 0 0 1",
               addrB, fullB, wordsB, ifB.in_ready);
    else passes++;
    driveB(4'd2, 5'd6, 5'd7, 5'd8);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (weB !== 1'b1 || addrB !== 2'd0)
      $display("FAIL full_restart we=%b addr=%0d required we=1 addr=0", weB, addrB);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [1:0] expAddr;
    logic [2:0] expWords;
    for (int i = 0; i < 5; i++) begin
      expAddr  = 2'(1 + (i % 3));
      expWords = (i < 4) ? 3'(i) : 3'd4;
      driveC(4'd0, 5'd1, 5'd2, 5'(i));
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (weC !== 1'b1 || addrC !== expAddr || wordsC !== expWords)
        $display("FAIL wrap_write%0d we=%b addr=%0d words=%0d required we=1 addr=%0d words=%0d",
                 i, weC, addrC, wordsC, expAddr, expWords);
      else begin
        passes++;
        $display("wrap write addr=%0d words=%0d", addrC, wordsC);
      end
      @(negedge clk);
    end
    checks++;
    if (wordsC !== 3'd4 || fullC !== 1'b0 || ifC.in_ready !== 1'b1)
      $display("FAIL wrap_saturate words=%0d full=%b ready=%b required 4 0 1", wordsC, fullC, ifC.in_ready);
    else passes++;
  endtask

  initial begin
    rst_n  = 1'b0;
    clearA = 1'b0;
    clearB = 1'b0;
    clearC = 1'b0;
    ifA.in_valid = 1'b0; ifA.in_mnem = '0; ifA.in_rs = '0; ifA.in_rt = '0;
    ifA.in_rd = '0; ifA.in_shamt = '0; ifA.in_imm = '0;
    ifB.in_valid = 1'b0; ifB.in_mnem = '0; ifB.in_rs = '0; ifB.in_rt = '0;
    ifB.in_rd = '0; ifB.in_shamt = '0; ifB.in_imm = '0;
    ifC.in_valid = 1'b0; ifC.in_mnem = '0; ifC.in_rs = '0; ifC.in_rt = '0;
    ifC.in_rd = '0; ifC.in_shamt = '0; ifC.in_imm = '0;

    test_reset();
    test_add();
    test_itype();
    test_rtype_mix();
    test_illegal();
    test_back_to_back();
    test_clear();
    test_reset_mid_write();
    test_full_nowrap();
    test_wrap();

    checks++;
    if (sbA.size() != 0) $display("FAIL scoreboard_drained pending=%0d required=0", sbA.size());
    else passes++;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
